nibble_serial_adder_ctrl: RTL
=============================

# nibble_serial_adder_ctrl

Sequencing controller that wraps the team's combinational 4-bit carry adder to perform multi-nibble additions, one nibble per clock, LSB nibble first. It latches two wide operands and a carry-in, drives the adder's A/B/C inputs each cycle, and captures the adder's S/D outputs into a wide result register. It sits directly around the 4-bit adder: upstream as its operand feeder, downstream as its result consumer.

## Interface
- NIBBLES, 4: number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high; one clock domain only.
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A; sampled on the accepting edge.
- op_b  in  W  operand B; sampled on the accepting edge.
- cin  in  1  carry-in; sampled on the accepting edge.
- add_a  out  4  to adder A: current nibble of latched op_a.
- add_b  out  4  to adder B: current nibble of latched op_b.
- add_c  out  1  to adder C: running carry register.
- add_s  in  4  from adder S (sum nibble).
- add_d  in  1  from adder D (carry out).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- sum  out  W  result register.
- cout  out  1  final carry-out.
- ovf  out  1  signed overflow (only with SIGNED_OVF_EN).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: add_a/add_b/add_c driven 0. If start=1: latch op_a, op_b; carry_reg<=cin; idx<=0; go RUN.
- RUN: add_a=op_a_reg[4*idx+3:4*idx], add_b likewise, add_c=carry_reg. Each edge: sum[4*idx+3:4*idx]<=add_s; carry_reg<=add_d; idx<=idx+1. On the edge where idx=NIBBLES-1: cout<=add_d, go DONE.
- DONE: done=1 for exactly one cycle; add_* driven 0; next edge go IDLE unconditionally.
- start while RUN or DONE: ignored, not queued; op_a/op_b/cin changes after acceptance have no effect.
- sum/cout hold last values between operations; sum nibbles are overwritten progressively during RUN; sum valid only when done=1 and thereafter until next acceptance.
- Arithmetic: unsigned W-bit add; {cout,sum} = op_a+op_b+cin, exact modulo 2^(W+1).
- idx width = clog2(NIBBLES), minimum 1 bit; never exceeds NIBBLES-1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, add_a=0, add_b=0, add_c=0, idx=0, carry_reg=0.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with all reset values; partial sum discarded; no done pulse.
- Edge T0 accepts start; busy=1 from T0 to TN; nibble k captured at edge T(k+1); cout captured at TN; done=1 from TN to TN+1; IDLE after TN+1.
- Latency start-edge to done-high: NIBBLES edges. Throughput: one operation per NIBBLES+2 cycles (start may be reasserted during DONE but is sampled only after TN+1).
- Adder path is combinational: add_* to add_s/add_d must settle within one clk period.

## Configuration
- SIGNED_OVF_EN defined: ovf port exists; at TN, ovf<=(op_a_reg[W-1]==op_b_reg[W-1]) && (add_s[3]!=op_a_reg[W-1]); holds until next TN or reset.
- SIGNED_OVF_EN undefined: ovf port and its logic absent; all other behaviour identical.

## Test plan
- NIBBLES=4, op_a=0x1234, op_b=0x4321, cin=0, start one cycle -> busy for 4 cycles, done pulse 4 edges after accept, sum=0x5555, cout=0.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> sum=0x0000, cout=1; carry ripples through all four nibble beats (add_c=1 on beats 1..3).
- op_a=0x000F, op_b=0x0001, cin=1 -> sum=0x0011, cout=0; start re-pulsed during RUN ignored, exactly one done pulse.
- Accept 0x1111+0x1111, assert rst after 2 RUN beats, release, then 0x0002+0x0003 -> all outputs 0 during reset, no done for aborted op, second result sum=0x0005.
- SIGNED_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; then 0xFFFF+0x0001 -> ovf=0, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a combinational 4-bit carry adder over NIBBLES nibbles, LSB nibble first.
// Optional signed-overflow output is enabled by defining SIGNED_OVF_EN.
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_c,
    input  logic [3:0]           add_s,
    input  logic                 add_d,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout
`ifdef SIGNED_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     op_a_reg;
    logic [W-1:0]     op_b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;

    // Adder operands are only presented during RUN so the adder sees zeros otherwise.
    always_comb begin
        add_a = '0;
        add_b = '0;
        add_c = 1'b0;
        if (state == RUN) begin
            add_a = op_a_reg[4*idx +: 4];
            add_b = op_b_reg[4*idx +: 4];
            add_c = carry_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a_reg  <= op_a;
                        op_b_reg  <= op_b;
                        carry_reg <= cin;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= add_s;
                    carry_reg       <= add_d;
                    if (idx == LAST_IDX) begin
                        cout  <= add_d;
`ifdef SIGNED_OVF_EN
                        ovf   <= (op_a_reg[W-1] == op_b_reg[W-1]) &&
                                 (add_s[3] != op_a_reg[W-1]);
`endif
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
